// File: rtl/fft_loader.sv
// Front end of the 64-point FFT: writes incoming samples at bit-reversed RAM
// addresses, then runs the core through clear/start/run/drain for each frame.
module fft_loader #(
    parameter int DRAIN_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] sample,
    output logic        sample_ready,
    output logic        fft_reset,
    output logic        load,
    output logic [5:0]  load_address,
    output logic [31:0] data_in,
    output logic        start,
    input  logic        fft_done,
    output logic        spectrum_valid,
    output logic        dropped
);

    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        CLEAR,
        FILL,
        START,
        RUN,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          dropped_q, dropped_d;
    logic          accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            drain_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            dropped_q <= dropped_d;
        end
    end

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        drain_d        = drain_q;
        sample_ready   = (state_q == FILL);
        fft_reset      = (state_q == CLEAR);
        start          = (state_q == START);
        spectrum_valid = (state_q == DRAIN);
        dropped        = dropped_q;
        accept         = sample_valid && sample_ready;
        dropped_d      = dropped_q | (sample_valid & ~sample_ready);
        load           = accept;
        load_address   = '0;
        data_in        = '0;

        // The RAM write happens on the accepting edge, so address and data are combinational.
        if (accept) begin
            for (int i = 0; i < 6; i++) begin
                load_address[i] = cnt_q[5-i];
            end
            data_in = {sample, 16'h0000};
        end

        case (state_q)
            CLEAR: begin
                state_d = FILL;
                cnt_d   = '0;
            end
            FILL: begin
                if (accept) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd63) begin
                        state_d = START;
                    end
                end
            end
            START: state_d = RUN;
            RUN: begin
                if (fft_done) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                drain_d = drain_q + DW'(1);
                if (drain_q == DRAIN_LAST) begin
                    state_d = CLEAR;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

endmodule

// File: tb/tb_fft_loader.sv
// Directed frame sequence with random samples; a behavioural RAM image and
// frame timeline model supply every expected value.
module tb_fft_loader;

    localparam int DRAIN = 64;

    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample       = '0;
    logic        fft_done     = 1'b0;
    logic        sample_ready, fft_reset, load, start, spectrum_valid, dropped;
    logic [5:0]  load_address;
    logic [31:0] data_in;

    int          checks  = 0;
    int          errors  = 0;
    logic        dropped_exp = 1'b0;
    logic [31:0] ram   [64];
    logic [15:0] exp_s [64];

    fft_loader #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample         (sample),
        .sample_ready   (sample_ready),
        .fft_reset      (fft_reset),
        .load           (load),
        .load_address   (load_address),
        .data_in        (data_in),
        .start          (start),
        .fft_done       (fft_done),
        .spectrum_valid (spectrum_valid),
        .dropped        (dropped)
    );

    always #5 clk = ~clk;

    // Stand-in for the FFT input RAM: captures whatever the loader writes.
    always @(posedge clk) begin
        if (load === 1'b1) ram[load_address] <= data_in;
    end

    function automatic logic [5:0] bitrev(input int k);
        int r = 0;
        for (int i = 0; i < 6; i++) r = (r << 1) | ((k >> i) & 1);
        return 6'(r);
    endfunction

    function automatic logic [31:0] ctrl_now();
        return {27'd0, sample_ready, fft_reset, start, spectrum_valid, dropped};
    endfunction

    function automatic logic [31:0] ctrl_exp(input logic rdy, input logic clr,
                                             input logic st, input logic sv);
        return {27'd0, rdy, clr, st, sv, dropped_exp};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offers samples every gap-th cycle until n have been accepted.
    task automatic fill(input int n, input int gap, input bit ramp);
        int acc = 0;
        int cyc = 0;
        int load_cnt = 0;
        while (acc < n) begin
            @(negedge clk);
            sample_valid = ((cyc % gap) == gap - 1);
            sample       = ramp ? 16'(acc << 4) : 16'($urandom);
            fft_done     = (gap > 1) ? 1'($urandom) : 1'b0;
            #1;
            chk("fill_ctrl", ctrl_now(), ctrl_exp(1'b1, 1'b0, 1'b0, 1'b0));
            chk("fill_load", {31'd0, load}, {31'd0, sample_valid});
            chk("fill_addr", {26'd0, load_address}, sample_valid ? {26'd0, bitrev(acc)} : 32'd0);
            chk("fill_data", data_in, sample_valid ? {sample, 16'h0000} : 32'd0);
            if (ramp && sample_valid) begin
                case (acc)
                    0:  chk("addr_k0",  {26'd0, load_address}, 32'd0);
                    1:  chk("addr_k1",  {26'd0, load_address}, 32'd32);
                    2:  chk("addr_k2",  {26'd0, load_address}, 32'd16);
                    5:  chk("data_k5",  data_in, 32'h0050_0000);
                    6:  chk("addr_k6",  {26'd0, load_address}, 32'd24);
                    63: chk("addr_k63", {26'd0, load_address}, 32'd63);
                    default: ;
                endcase
            end
            if (load === 1'b1) load_cnt++;
            if (sample_valid) begin
                exp_s[acc] = sample;
                acc++;
            end
            cyc++;
        end
        chk("fill_loads", load_cnt, n);
    endtask

    task automatic start_check();
        @(negedge clk);
        sample_valid = 1'b0;
        fft_done     = 1'b0;
        #1;
        chk("start_pulse", ctrl_now(), ctrl_exp(1'b0, 1'b0, 1'b1, 1'b0));
        chk("start_load", {31'd0, load}, 32'd0);
        for (int k = 0; k < 64; k++) begin
            chk("ram_image", ram[bitrev(k)], {exp_s[k], 16'h0000});
        end
    endtask

    task automatic run_drain(input int run_len, input bit hold);
        int n = 0;
        for (int i = 0; i < run_len; i++) begin
            @(negedge clk);
            sample_valid = hold;
            sample       = 16'($urandom);
            #1;
            chk("run_ctrl", ctrl_now(), ctrl_exp(1'b0, 1'b0, 1'b0, 1'b0));
            chk("run_load", {31'd0, load}, 32'd0);
            if (hold) dropped_exp = 1'b1;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        fft_done     = 1'b1;
        #1;
        chk("done_seen", ctrl_now(), ctrl_exp(1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < DRAIN + 10; i++) begin
            @(negedge clk);
            #1;
            if (spectrum_valid !== 1'b1) break;
            chk("drain_ctrl", ctrl_now(), ctrl_exp(1'b0, 1'b0, 1'b0, 1'b1));
            n++;
        end
        chk("drain_len", n, DRAIN);
        chk("clear_ctrl", ctrl_now(), ctrl_exp(1'b0, 1'b1, 1'b0, 1'b0));
        fft_done = 1'b0;
    endtask

    initial begin
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("reset_ctrl", ctrl_now(), ctrl_exp(1'b0, 1'b1, 1'b0, 1'b0));
            chk("reset_load", {31'd0, load}, 32'd0);
            chk("reset_addr", {26'd0, load_address}, 32'd0);
            chk("reset_data", data_in, 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("release_clear", ctrl_now(), ctrl_exp(1'b0, 1'b1, 1'b0, 1'b0));

        // Frame 1: back-to-back ramp, done 200 cycles after start.
        fill(64, 1, 1'b1);
        start_check();
        run_drain(199, 1'b0);

        // Frame 2: gapped random source, then samples offered throughout RUN.
        fill(64, 3, 1'b0);
        start_check();
        run_drain(150, 1'b1);

        // Frame 3: abandoned by reset after 20 samples, then a full refill.
        fill(20, 1, 1'b0);
        @(negedge clk);
        sample_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        dropped_exp  = 1'b0;
        #1;
        chk("abort_clear", ctrl_now(), ctrl_exp(1'b0, 1'b1, 1'b0, 1'b0));
        chk("abort_load", {31'd0, load}, 32'd0);
        fill(64, 1, 1'b0);
        start_check();
        run_drain(10, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
